// File: rtl/ct_ifu_tage_array_ctrl.sv
// TAGE prediction table SRAM controller: zero-init sweep, read/update arbitration
// with a 2-entry update queue and bounded write starvation; all SRAM pins registered.
module ct_ifu_tage_array_ctrl #(
    parameter int DEPTH      = 1024,
    parameter int INDEX_W    = 10,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic               ifu_tage_inv,
    input  logic               pred_rd_vld,
    input  logic [INDEX_W-1:0] pred_rd_index,
    output logic               pred_rd_ready,
    output logic               pred_rd_data_vld,
    output logic [DATA_W-1:0]  pred_rd_data,
    input  logic               upd_vld,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [DATA_W-1:0]  upd_data,
    input  logic [DATA_W-1:0]  upd_mask,
    output logic               upd_ready,
    output logic               tage_init_done,
    input  logic [DATA_W-1:0]  tage_pre_data_out,
    output logic               tage_pred_array_clk_en,
    output logic               tage_pred_array_cen_b,
    output logic               tage_pred_array_gwen,
    output logic [INDEX_W-1:0] tage_pred_array_index,
    output logic [DATA_W-1:0]  tage_pred_array_din,
    output logic [DATA_W-1:0]  tage_pred_bwen
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [INDEX_W-1:0]  init_cnt;
    logic [STARVE_W-1:0] starve;

    logic [INDEX_W-1:0]  q_index [2];
    logic [DATA_W-1:0]   q_data  [2];
    logic [DATA_W-1:0]   q_mask  [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          q_count;

    logic rd_pipe;
    logic run, q_empty, q_full, force_wr, rd_issue, wr_issue, init_issue, push;

    always_comb begin
        run           = (state == RUN) && !ifu_tage_inv;
        q_empty       = (q_count == 2'd0);
        q_full        = (q_count == 2'd2);
        force_wr      = run && !q_empty && (starve == STARVE_W'(STARVE_MAX));
        pred_rd_ready = run && !force_wr;
        upd_ready     = run && !q_full;
        rd_issue      = pred_rd_ready && pred_rd_vld;
        wr_issue      = force_wr || (run && !pred_rd_vld && !q_empty);
        init_issue    = (state == INIT) && !ifu_tage_inv;
        push          = upd_vld && upd_ready;
    end

    assign pred_rd_data = tage_pre_data_out;

    // FSM, sweep counter and the registered SRAM pins
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state                  <= INIT;
            init_cnt               <= '0;
            tage_init_done         <= 1'b0;
            tage_pred_array_clk_en <= 1'b0;
            tage_pred_array_cen_b  <= 1'b1;
            tage_pred_array_gwen   <= 1'b1;
            tage_pred_array_index  <= '0;
            tage_pred_array_din    <= '0;
            tage_pred_bwen         <= '1;
        end else begin
            if (ifu_tage_inv) begin
                state          <= INIT;
                init_cnt       <= '0;
                tage_init_done <= 1'b0;
            end else if (state == INIT) begin
                init_cnt <= init_cnt + INDEX_W'(1);
                if (init_cnt == INDEX_W'(DEPTH - 1)) begin
                    state          <= RUN;
                    tage_init_done <= 1'b1;
                end
            end

            if (init_issue) begin
                tage_pred_array_clk_en <= 1'b1;
                tage_pred_array_cen_b  <= 1'b0;
                tage_pred_array_gwen   <= 1'b0;
                tage_pred_array_index  <= init_cnt;
                tage_pred_array_din    <= '0;
                tage_pred_bwen         <= '0;
            end else if (rd_issue) begin
                tage_pred_array_clk_en <= 1'b1;
                tage_pred_array_cen_b  <= 1'b0;
                tage_pred_array_gwen   <= 1'b1;
                tage_pred_array_index  <= pred_rd_index;
                tage_pred_bwen         <= '1;
            end else if (wr_issue) begin
                tage_pred_array_clk_en <= 1'b1;
                tage_pred_array_cen_b  <= 1'b0;
                tage_pred_array_gwen   <= 1'b0;
                tage_pred_array_index  <= q_index[rd_ptr];
                tage_pred_array_din    <= q_data[rd_ptr];
                tage_pred_bwen         <= ~q_mask[rd_ptr];
            end else begin
                tage_pred_array_clk_en <= 1'b0;
                tage_pred_array_cen_b  <= 1'b1;
                tage_pred_array_gwen   <= 1'b1;
                tage_pred_bwen         <= '1;
            end
        end
    end

    // Queue pointers, occupancy and starvation tracking
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            q_count <= 2'd0;
            starve  <= '0;
        end else if (ifu_tage_inv) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            q_count <= 2'd0;
            starve  <= '0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (wr_issue)
                rd_ptr <= ~rd_ptr;
            case ({push, wr_issue})
                2'b10:   q_count <= q_count + 2'd1;
                2'b01:   q_count <= q_count - 2'd1;
                default: q_count <= q_count;
            endcase
            if (wr_issue || q_empty)
                starve <= '0;
            else if (starve != STARVE_W'(STARVE_MAX))
                starve <= starve + STARVE_W'(1);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (push) begin
            q_index[wr_ptr] <= upd_index;
            q_data[wr_ptr]  <= upd_data;
            q_mask[wr_ptr]  <= upd_mask;
        end
    end

    // Reads issued before an invalidate still return their data
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_pipe          <= 1'b0;
            pred_rd_data_vld <= 1'b0;
        end else begin
            rd_pipe          <= rd_issue;
            pred_rd_data_vld <= rd_pipe;
        end
    end

endmodule

// File: tb/tb_ct_ifu_tage_array_ctrl.sv
// Directed bench for ct_ifu_tage_array_ctrl with a behavioural 1024x64 bit-write SRAM.
module tb_ct_ifu_tage_array_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inv = 1'b0;
    logic        rd_vld = 1'b0;
    logic [9:0]  rd_idx = '0;
    logic        rd_rdy;
    logic        rd_data_vld;
    logic [63:0] rd_data;
    logic        upd_vld = 1'b0;
    logic [9:0]  upd_idx = '0;
    logic [63:0] upd_data = '0;
    logic [63:0] upd_mask = '0;
    logic        upd_rdy;
    logic        done;
    logic [63:0] sram_q;
    logic        clk_en, cen_b, gwen;
    logic [9:0]  index;
    logic [63:0] din, bwen;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_rdy [7] = '{1, 1, 1, 1, 1, 0, 1};
    logic [63:0] mem [1024];

    ct_ifu_tage_array_ctrl #(
        .DEPTH(1024), .INDEX_W(10), .DATA_W(64), .STARVE_MAX(4)
    ) dut (
        .forever_cpuclk         (clk),
        .cpurst                 (rst),
        .ifu_tage_inv           (inv),
        .pred_rd_vld            (rd_vld),
        .pred_rd_index          (rd_idx),
        .pred_rd_ready          (rd_rdy),
        .pred_rd_data_vld       (rd_data_vld),
        .pred_rd_data           (rd_data),
        .upd_vld                (upd_vld),
        .upd_index              (upd_idx),
        .upd_data               (upd_data),
        .upd_mask               (upd_mask),
        .upd_ready              (upd_rdy),
        .tage_init_done         (done),
        .tage_pre_data_out      (sram_q),
        .tage_pred_array_clk_en (clk_en),
        .tage_pred_array_cen_b  (cen_b),
        .tage_pred_array_gwen   (gwen),
        .tage_pred_array_index  (index),
        .tage_pred_array_din    (din),
        .tage_pred_bwen         (bwen)
    );

    always #5 clk = ~clk;

    // SRAM model: active-low enables, active-low bit write, 1-cycle read latency
    always @(posedge clk) begin
        if (clk_en && !cen_b) begin
            if (!gwen)
                mem[index] <= (mem[index] & bwen) | (din & ~bwen);
            else
                sram_q <= mem[index];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int n, input bit full, input string tag);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if ({cen_b, gwen, clk_en} !== 3'b001 || index !== 10'(k) || din !== '0 || bwen !== '0)
                bad++;
            if (!(full && k == n - 1) && (done !== 1'b0 || rd_rdy !== 1'b0 || upd_rdy !== 1'b0))
                bad++;
        end
        check({tag, "_sweep"}, 64'(bad), 64'd0);
        if (full)
            check({tag, "_done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic do_read(input logic [9:0] idx, input logic [63:0] expv, input string tag);
        rd_vld = 1'b1;
        rd_idx = idx;
        #1;
        check({tag, "_rdy"}, {63'd0, rd_rdy}, 64'd1);
        step();
        rd_vld = 1'b0;
        check({tag, "_pins"}, {51'd0, cen_b, gwen, clk_en, index}, {51'd0, 3'b011, idx});
        check({tag, "_early"}, {63'd0, rd_data_vld}, 64'd0);
        step();
        check({tag, "_vld"}, {63'd0, rd_data_vld}, 64'd1);
        check({tag, "_data"}, rd_data, expv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        for (int i = 0; i < 1024; i++)
            mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);

        // Reset values
        step(); step();
        check("rst_pins", {51'd0, cen_b, gwen, clk_en, index}, {51'd0, 3'b110, 10'd0});
        check("rst_din", din, 64'd0);
        check("rst_bwen", bwen, '1);
        check("rst_status", {60'd0, rd_data_vld, done, rd_rdy, upd_rdy}, 64'd0);

        // Init sweep with reads requested throughout
        rst = 1'b0;
        rd_vld = 1'b1;
        rd_idx = 10'd77;
        sweep(1024, 1'b1, "init");

        // Full-mask write then read back
        rd_vld = 1'b0;
        upd_vld = 1'b1;
        upd_idx = 10'd5;
        upd_data = 64'hA5A5_A5A5_A5A5_A5A5;
        upd_mask = '1;
        #1;
        check("upd_rdy_run", {63'd0, upd_rdy}, 64'd1);
        step();
        upd_vld = 1'b0;
        check("idle_pins", {61'd0, cen_b, gwen, clk_en}, {61'd0, 3'b110});
        check("idle_bwen", bwen, '1);
        step();
        check("wr5_pins", {51'd0, cen_b, gwen, clk_en, index}, {51'd0, 3'b001, 10'd5});
        check("wr5_din", din, 64'hA5A5_A5A5_A5A5_A5A5);
        check("wr5_bwen", bwen, 64'd0);
        do_read(10'd5, 64'hA5A5_A5A5_A5A5_A5A5, "rd5");
        do_read(10'd7, 64'd0, "rd7");

        // Partial mask
        upd_vld = 1'b1;
        upd_idx = 10'd9;
        upd_data = 64'h1234_5678_9ABC_DEF0;
        upd_mask = 64'h0000_0000_FFFF_FFFF;
        step();
        upd_vld = 1'b0;
        step();
        check("pm_pins", {51'd0, cen_b, gwen, clk_en, index}, {51'd0, 3'b001, 10'd9});
        check("pm_bwen", bwen, 64'hFFFF_FFFF_0000_0000);
        do_read(10'd9, 64'h0000_0000_9ABC_DEF0, "rd9");

        // Starvation bound with saturating reads
        rd_vld = 1'b1;
        rd_idx = 10'd3;
        upd_vld = 1'b1;
        upd_idx = 10'd12;
        upd_data = 64'h0F0F_0F0F_0F0F_0F0F;
        upd_mask = '1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("starve_rdy%0d", i), {63'd0, rd_rdy}, {63'd0, exp_rdy[i]});
            step();
            upd_vld = 1'b0;
            if (i == 5)
                check("starve_wr_pins", {51'd0, cen_b, gwen, clk_en, index}, {51'd0, 3'b001, 10'd12});
        end

        // Full queue holds a third update until the first pop
        upd_vld = 1'b1;
        upd_idx = 10'd20;
        upd_data = 64'h1111_2222_3333_4444;
        #1;
        check("qa_rdy", {63'd0, upd_rdy}, 64'd1);
        step();
        upd_idx = 10'd21;
        upd_data = 64'h5555_6666_7777_8888;
        #1;
        check("qb_rdy", {63'd0, upd_rdy}, 64'd1);
        step();
        upd_idx = 10'd22;
        upd_data = 64'h9999_AAAA_BBBB_CCCC;
        waited = 0;
        #1;
        while (!upd_rdy && waited < 20) begin
            step();
            waited++;
            #1;
        end
        check("full_hold_cycles", 64'(waited), 64'd4);
        step();
        upd_vld = 1'b0;
        rd_vld = 1'b0;
        step(); step();
        do_read(10'd22, 64'h9999_AAAA_BBBB_CCCC, "rd22");
        do_read(10'd20, 64'h1111_2222_3333_4444, "rd20");
        do_read(10'd21, 64'h5555_6666_7777_8888, "rd21");

        // Invalidate with two queued writes and a read in flight
        rd_vld = 1'b1;
        rd_idx = 10'd5;
        upd_vld = 1'b1;
        upd_idx = 10'd30;
        upd_data = 64'hFFFF_0000_FFFF_0000;
        step();
        upd_idx = 10'd31;
        step();
        upd_vld = 1'b0;
        step();
        inv = 1'b1;
        #1;
        check("inv_rdy", {62'd0, rd_rdy, upd_rdy}, 64'd0);
        step();
        inv = 1'b0;
        rd_vld = 1'b0;
        check("inv_inflight_vld", {63'd0, rd_data_vld}, 64'd1);
        check("inv_inflight_data", rd_data, 64'hA5A5_A5A5_A5A5_A5A5);
        check("inv_idle_pins", {62'd0, cen_b, done}, {62'd0, 2'b10});
        sweep(1024, 1'b1, "inv1");
        step();
        check("no_stale_write", {61'd0, cen_b, gwen, clk_en}, {61'd0, 3'b110});
        do_read(10'd30, 64'd0, "rd30");

        // Invalidate at the sweep midpoint
        inv = 1'b1;
        step();
        inv = 1'b0;
        rd_vld = 1'b1;
        sweep(512, 1'b0, "half");
        inv = 1'b1;
        step();
        inv = 1'b0;
        check("mid_inv_idle", {62'd0, cen_b, done}, {62'd0, 2'b10});
        sweep(1024, 1'b1, "inv2");
        rd_vld = 1'b0;

        // Reset asserted mid-operation
        rd_vld = 1'b1;
        rd_idx = 10'd3;
        step();
        rd_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst2_pins", {51'd0, cen_b, gwen, clk_en, index}, {51'd0, 3'b110, 10'd0});
        check("rst2_bwen", bwen, '1);
        check("rst2_status", {60'd0, rd_data_vld, done, rd_rdy, upd_rdy}, 64'd0);
        step(); step();
        rst = 1'b0;
        sweep(4, 1'b0, "rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_ifu_tage_array_ctrl.md
# ct_ifu_tage_array_ctrl

Sequencing and arbitration controller for one TAGE prediction table SRAM bank (1024x64, active-low CEN/GWEN/bit-WEN, 1-cycle read latency, gated clock). It shares the single-port array between prediction-pipeline reads and BHT/TAGE update writes. It buffers updates in a 2-entry queue and bounds write starvation. After reset or a cp0 invalidate, it zero-initialises the whole table. All SRAM-side outputs are registered and feed the array wrapper directly, including the clock enable for its gated clock cell.

## Interface
- DEPTH, 1024, table entries
- INDEX_W, 10, index width (log2 DEPTH)
- DATA_W, 64, entry width
- STARVE_MAX, 4, cycles a queued write may be deferred by reads before it takes priority
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset, asynchronous, active-high
- ifu_tage_inv  in  1  invalidate pulse; restarts the init sweep
- pred_rd_vld  in  1  prediction read request
- pred_rd_index  in  INDEX_W  read index
- pred_rd_ready  out  1  read accepted this cycle when pred_rd_vld=1 and pred_rd_ready=1
- pred_rd_data_vld  out  1  pred_rd_data valid
- pred_rd_data  out  DATA_W  read data, passed through from tage_pre_data_out
- upd_vld  in  1  update write request
- upd_index  in  INDEX_W  update index
- upd_data  in  DATA_W  update data
- upd_mask  in  DATA_W  active-high bit-write mask
- upd_ready  out  1  update accepted when upd_vld=1 and upd_ready=1
- tage_init_done  out  1  table initialised; normal operation
- tage_pre_data_out  in  DATA_W  SRAM Q
- tage_pred_array_clk_en  out  1  gated-clock local enable
- tage_pred_array_cen_b  out  1  chip enable, active-low
- tage_pred_array_gwen  out  1  global write enable, active-low
- tage_pred_array_index  out  INDEX_W  address
- tage_pred_array_din  out  DATA_W  write data
- tage_pred_bwen  out  DATA_W  bit write enable, active-low

## Operation
- FSM states:
  - INIT (reset state, counter=0). Each cycle issues a write of din=0, bwen=all-0 at index=counter, then increments the counter. After issuing index DEPTH-1, moves to RUN.
  - RUN. tage_init_done=1 only in RUN.
- ifu_tage_inv in any state sets next state INIT and counter=0, clears the queue and the starve counter, and forces pred_rd_ready=0 and upd_ready=0 that cycle. A read already issued to the SRAM still returns its data.
- In INIT: pred_rd_ready=0, upd_ready=0.
- Update queue: 2-entry FIFO of {index, data, mask}.
  - upd_ready = RUN and not full and not inv. It is not raised by a same-cycle pop.
  - A queued write issues gwen=0, cen_b=0, bwen=~mask.
- Arbitration in RUN, one SRAM access per cycle:
  - If the queue is non-empty and starve==STARVE_MAX: pop and write; pred_rd_ready=0.
  - Otherwise pred_rd_ready=1. If pred_rd_vld=1, issue the read (cen_b=0, gwen=1, bwen=all-1).
  - Otherwise, if the queue is non-empty, pop and write.
- Starve counter: increments, saturating at STARVE_MAX, in each cycle where the queue is non-empty and no write is issued. Resets to 0 on any write or when the queue is empty.
- An update pushed in cycle T may be popped no earlier than T+1.
- Read/write ordering is not enforced. A read to an index with a queued write returns the SRAM contents. Staleness is acceptable for prediction.
- Idle cycle (no access): cen_b=1, gwen=1, bwen=all-1, clk_en=0. index and din hold their last values.

## Timing
- Arbitration decision in cycle T; SRAM pins registered, so the SRAM sees the access in T+1 with clk_en=1 in T+1. The write completes at the end of T+1.
- Read accepted in T: pred_rd_data_vld=1 in T+2, with pred_rd_data = tage_pre_data_out.
- Init sweep: first write on the pins in the cycle after reset deasserts. tage_init_done rises the cycle after the last init write is decided, DEPTH cycles after the sweep starts.
- Reset values:
  - cen_b=1, gwen=1, bwen=all-1, index=0, din=0, clk_en=0.
  - pred_rd_data_vld=0, tage_init_done=0, pred_rd_ready=0, upd_ready=0.
  - Queue empty, starve=0.
- Reset asserted mid-operation immediately returns to the reset values and restarts the sweep after release.

## Test plan
- Reset release -> 1024 consecutive writes, index 0..1023, din=0, bwen=0. tage_init_done=1 at cycle 1025. No pred_rd_ready or upd_ready before then.
- Write then read: update idx 5, data 0xA5A5..., mask all-1; a read of idx 5 later -> pred_rd_data_vld two cycles after acceptance, data 0xA5A5...
- Partial mask: mask=0x0000_0000_FFFF_FFFF -> pins show bwen=0xFFFF_FFFF_0000_0000.
- Continuous pred_rd_vld with 1 queued update -> 4 reads accepted, then pred_rd_ready=0 for one cycle and the write issues, then reads resume.
- Two updates queued and reads saturating -> upd_ready=0. A third upd_vld is held until the first pop, then accepted.
- ifu_tage_inv with 2 queued writes at sweep midpoint -> queue dropped, index restarts at 0, tage_init_done=0 until 1024 writes complete.
